// File: rtl/div_seq_ctrl_pkg.sv
// Shared encodings for the RV32M divide/remainder sequencer.
// Operation codes, FSM state encodings and small decode helpers.
package div_seq_ctrl_pkg;

  typedef logic [1:0] div_op_t;
  typedef logic [1:0] div_state_t;

  localparam div_op_t DIVOP_DIV  = 2'b00;
  localparam div_op_t DIVOP_DIVU = 2'b01;
  localparam div_op_t DIVOP_REM  = 2'b10;
  localparam div_op_t DIVOP_REMU = 2'b11;

  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_CALC = 2'd1;
  localparam div_state_t DIV_FIX  = 2'd2;
  localparam div_state_t DIV_DONE = 2'd3;

  function automatic logic divop_is_signed(input div_op_t op);
    return (op == DIVOP_DIV) || (op == DIVOP_REM);
  endfunction

  function automatic logic divop_is_rem(input div_op_t op);
    return (op == DIVOP_REM) || (op == DIVOP_REMU);
  endfunction

endpackage

// File: rtl/div_seq_ctrl_iter_step.sv
// One radix-2 restoring shift-subtract step on unsigned magnitudes.
module div_iter_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // rem < divisor, so the shifted value needs one extra bit and a
  // non-negative difference always fits back into XLEN bits.
  assign trial = {rem_i, quo_i[XLEN-1]};
  assign diff  = trial - {1'b0, divisor_i};

  always_comb begin
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = trial[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// EX-stage multi-cycle divide/remainder sequencer (div, divu, rem, remu).
// Stalls the pipeline while iterating; flush discards in-flight work.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      div_op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, is_rem_q, is_rem_d;
  logic [XLEN-1:0]  step_rem, step_quo;
  logic             sgn, a_neg, b_neg;

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign sgn   = divop_is_signed(div_op_i);
  assign a_neg = sgn & dividend_i[XLEN-1];
  assign b_neg = sgn & divisor_i[XLEN-1];

  assign busy_o   = (state_q != DIV_IDLE);
  assign done_o   = (state_q == DIV_DONE) & ~flush_i;
  assign stall_o  = start_i & ~done_o & ~flush_i;
  assign result_o = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_rem_d = is_rem_q;
    if (flush_i) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            is_rem_d = divop_is_rem(div_op_i);
            q_neg_d  = (a_neg ^ b_neg) & (divisor_i != '0);
            r_neg_d  = a_neg;
            dvsr_d   = b_neg ? -divisor_i : divisor_i;
            // Special cases preload final magnitudes and pass through FIX
            // with negation disabled, giving a two-cycle turnaround.
            if (divisor_i == '0) begin
              quo_d   = '1;
              rem_d   = dividend_i;
              q_neg_d = 1'b0;
              r_neg_d = 1'b0;
              state_d = DIV_FIX;
            end else if (sgn && dividend_i == XMIN && divisor_i == '1) begin
              quo_d   = XMIN;
              rem_d   = '0;
              q_neg_d = 1'b0;
              r_neg_d = 1'b0;
              state_d = DIV_FIX;
            end else begin
              quo_d   = a_neg ? -dividend_i : dividend_i;
              rem_d   = '0;
              cnt_d   = CNT_W'(XLEN - 1);
              state_d = DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == '0) begin
            state_d = DIV_FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DIV_FIX: begin
          if (is_rem_q) result_d = r_neg_q ? -rem_q : rem_q;
          else          result_d = q_neg_q ? -quo_q : quo_q;
          state_d = DIV_DONE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_rem_q <= is_rem_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i && (state_q == DIV_CALC || state_q == DIV_FIX))
      assert (start_i) else $error("div_seq_ctrl: start_i dropped mid-operation");
  end
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized bench for div_seq_ctrl against an arithmetic reference model.
module tb_div_seq_ctrl;
  import div_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start_i, flush_i;
  logic [1:0]  div_op_i;
  logic [31:0] dividend_i, divisor_i, result_o;
  logic        stall_o, busy_o, done_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] last_exp = '0;

  div_seq_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .div_op_i   (div_op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V semantics computed with wide signed arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op == DIVOP_DIVU) return a / b;
    if (op == DIVOP_REMU) return a % b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int unsigned ref_lat(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'd0) return 2;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Called at a negedge; leaves the bench at the negedge of the done cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit keep);
    logic [31:0] exp_r;
    int unsigned exp_l, n;
    exp_r = ref_div(op, a, b);
    exp_l = ref_lat(op, a, b);
    div_op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
    if (busy_o) begin
      @(negedge clk);
      chk_eq("b2b_idle", {31'd0, busy_o}, 32'd0);
    end
    #1 chk_eq("accept_stall", {31'd0, stall_o}, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done_o) begin
        chk_eq("stall_held", {31'd0, stall_o}, 32'd1);
        dividend_i = $urandom;
        divisor_i  = $urandom;
        div_op_i   = 2'($urandom);
      end
    end while (!done_o && n < 40);
    chk_eq("latency", n, exp_l);
    chk_eq("result", result_o, exp_r);
    chk_eq("done_stall", {31'd0, stall_o}, 32'd0);
    last_exp = exp_r;
    if (!keep) start_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  op;
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    div_op_i = '0; dividend_i = '0; divisor_i = '0;
    repeat (2) @(negedge clk);
    chk_eq("rst_done",   {31'd0, done_o}, 32'd0);
    chk_eq("rst_busy",   {31'd0, busy_o}, 32'd0);
    chk_eq("rst_result", result_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(DIVOP_DIVU, 32'd100, 32'd7, 0);
    do_op(DIVOP_REMU, 32'd100, 32'd7, 0);
    do_op(DIVOP_DIV,  32'hFFFF_FFF9, 32'd2, 0);
    do_op(DIVOP_REM,  32'hFFFF_FFF9, 32'd2, 0);
    do_op(DIVOP_DIV,  32'd5, 32'd0, 0);
    do_op(DIVOP_REM,  32'd5, 32'd0, 0);
    do_op(DIVOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(DIVOP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Flush at CALC cycle 10, then a new op in the very next cycle.
    div_op_i = DIVOP_DIVU; dividend_i = $urandom; divisor_i = $urandom | 32'd1;
    start_i = 1'b1;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1 chk_eq("flush_done",  {31'd0, done_o}, 32'd0);
    chk_eq("flush_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    chk_eq("flush_idle",   {31'd0, busy_o}, 32'd0);
    chk_eq("flush_result", result_o, last_exp);
    do_op(DIVOP_DIVU, 32'd9, 32'd3, 0);

    // Flush landing on the DONE cycle suppresses the pulse.
    div_op_i = DIVOP_DIV; dividend_i = 32'd5; divisor_i = 32'd0; start_i = 1'b1;
    repeat (2) @(negedge clk);
    flush_i = 1'b1;
    #1 chk_eq("flush_in_done", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    chk_eq("flush_in_done_idle", {31'd0, busy_o}, 32'd0);
    @(negedge clk);

    do_op(DIVOP_DIVU, 32'd10, 32'd3, 1);
    do_op(DIVOP_REMU, 32'd10, 32'd3, 0);

    // Reset during CALC.
    div_op_i = DIVOP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk_eq("midrst_done",   {31'd0, done_o}, 32'd0);
    chk_eq("midrst_busy",   {31'd0, busy_o}, 32'd0);
    chk_eq("midrst_stall",  {31'd0, stall_o}, 32'd0);
    chk_eq("midrst_result", result_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = $urandom_range(1, 15);
        3:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_op(op, a, b, ($urandom_range(0, 1) == 1));
    end
    start_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
